// File: rtl/regfile_sb.sv
// Register file with per-register busy (scoreboard) bits for in-order issue / out-of-order writeback.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data and busy release to the read ports.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [ADDR_W:0]   busy_count,
  output logic              err_wb_idle
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic issue_zero;
  logic wb_zero;
  logic set_en;
  logic wb_act;
  logic clr_en;
  logic wb_idle;
  logic rs1_zero;
  logic rs2_zero;

  assign issue_zero = (ZERO_REG != 0) && (issue_rd == '0);
  assign wb_zero    = (ZERO_REG != 0) && (wb_rd == '0);
  assign rs1_zero   = (ZERO_REG != 0) && (rs1 == '0);
  assign rs2_zero   = (ZERO_REG != 0) && (rs2 == '0);

  // Register 0 is never marked busy when hardwired, so it always reports ready.
  assign issue_ready = ~busy[issue_rd];
  assign set_en      = issue_valid && issue_ready && !issue_zero;
  assign wb_act      = wb_en && !wb_zero;
  assign clr_en      = wb_act && busy[wb_rd];
  // A same-edge reservation of the written index counts as a legitimate owner.
  assign wb_idle     = wb_act && !busy[wb_rd] && !(set_en && (issue_rd == wb_rd));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_act) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // The set is applied after the clear so a same-index issue keeps the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wb_act) begin
        busy[wb_rd] <= 1'b0;
      end
      if (set_en) begin
        busy[issue_rd] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_count <= '0;
    end else begin
      case ({set_en, clr_en})
        2'b10:   busy_count <= busy_count + CNT_ONE;
        2'b01:   busy_count <= busy_count - CNT_ONE;
        default: busy_count <= busy_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_wb_idle <= 1'b0;
    end else if (wb_idle) begin
      err_wb_idle <= 1'b1;
    end
  end

  always_comb begin
    rd_data1 = regs[rs1];
    rs1_busy = busy[rs1];
    rd_data2 = regs[rs2];
    rs2_busy = busy[rs2];
    if (rs1_zero) begin
      rd_data1 = '0;
      rs1_busy = 1'b0;
    end
    if (rs2_zero) begin
      rd_data2 = '0;
      rs2_busy = 1'b0;
    end
`ifdef REGFILE_SB_BYPASS_EN
    if (wb_act && (wb_rd == rs1)) begin
      rd_data1 = wb_data;
      rs1_busy = 1'b0;
    end
    if (wb_act && (wb_rd == rs2)) begin
      rd_data2 = wb_data;
      rs2_busy = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: array-level reference model compared every cycle plus directed literal checks.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [5:0]  busy_count;
  logic        err_wb_idle;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_err;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1(rs1), .rs2(rs2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_count(busy_count), .err_wb_idle(err_wb_idle)
  );

  always #5 clk = ~clk;

  // Reference model: registers, busy set and sticky error as plain arrays.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      m_busy <= 32'h0;
      m_err  <= 1'b0;
    end else begin
      if (wb_en && wb_rd != 5'd0) begin
        m_regs[wb_rd] <= wb_data;
        m_busy[wb_rd] <= 1'b0;
        if (!m_busy[wb_rd] && !(issue_valid && issue_rd == wb_rd)) m_err <= 1'b1;
      end
      if (issue_valid && issue_rd != 5'd0 && !m_busy[issue_rd]) m_busy[issue_rd] <= 1'b1;
    end
  end

  function automatic bit fwd_hit(input logic [4:0] rs);
`ifdef REGFILE_SB_BYPASS_EN
    return wb_en && (wb_rd == rs) && (rs != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (fwd_hit(rs)) return wb_data;
    return m_regs[rs];
  endfunction

  function automatic logic exp_busy(input logic [4:0] rs);
    if (fwd_hit(rs)) return 1'b0;
    return m_busy[rs];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [4:0] ird, input logic we,
                               input logic [4:0] wrd, input logic [31:0] wd,
                               input logic [4:0] r1, input logic [4:0] r2);
    issue_valid = iv;
    issue_rd    = ird;
    wb_en       = we;
    wb_rd       = wrd;
    wb_data     = wd;
    rs1         = r1;
    rs2         = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cmp_rd_data1", 64'(rd_data1), 64'(exp_data(rs1)));
      checkOutput("cmp_rd_data2", 64'(rd_data2), 64'(exp_data(rs2)));
      checkOutput("cmp_rs1_busy", 64'(rs1_busy), 64'(exp_busy(rs1)));
      checkOutput("cmp_rs2_busy", 64'(rs2_busy), 64'(exp_busy(rs2)));
      checkOutput("cmp_issue_ready", 64'(issue_ready), 64'(!m_busy[issue_rd]));
      checkOutput("cmp_busy_count", 64'(busy_count), 64'($countones(m_busy)));
      checkOutput("cmp_err_wb_idle", 64'(err_wb_idle), 64'(m_err));
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 5, 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    #1;
    checkOutput("reset_count", 64'(busy_count), 64'd0);
    checkOutput("reset_err", 64'(err_wb_idle), 64'd0);
    checkOutput("reset_rd1", 64'(rd_data1), 64'd0);
    checkOutput("reset_ready", 64'(issue_ready), 64'd1);

    // WAW stall on r7, then writeback releases it
    applyStimulus(1, 7, 0, 0, 0, 7, 0);
    #1 checkOutput("r7_first_ready", 64'(issue_ready), 64'd1);
    tick();
    #1;
    checkOutput("r7_busy", 64'(rs1_busy), 64'd1);
    checkOutput("r7_second_ready", 64'(issue_ready), 64'd0);
    checkOutput("r7_count1", 64'(busy_count), 64'd1);
    tick();
    #1 checkOutput("r7_count_held", 64'(busy_count), 64'd1);
    applyStimulus(0, 0, 1, 7, 32'h12345678, 7, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 7, 0);
    #1;
    checkOutput("r7_data", 64'(rd_data1), 64'h12345678);
    checkOutput("r7_released", 64'(rs1_busy), 64'd0);
    checkOutput("r7_count0", 64'(busy_count), 64'd0);

    // Same-edge issue and writeback of idle r3
    applyStimulus(1, 3, 1, 3, 32'hA5A5A5A5, 3, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    #1;
    checkOutput("r3_data", 64'(rd_data1), 64'hA5A5A5A5);
    checkOutput("r3_busy", 64'(rs1_busy), 64'd1);
    checkOutput("r3_count", 64'(busy_count), 64'd1);
    checkOutput("r3_no_err", 64'(err_wb_idle), 64'd0);
    applyStimulus(0, 0, 1, 3, 32'h33333333, 3, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 3, 0);
    #1 checkOutput("r3_count0", 64'(busy_count), 64'd0);

    // Overlapping issue of r11 with writeback of r10 keeps the count steady
    applyStimulus(1, 10, 0, 0, 0, 10, 11);
    tick();
    applyStimulus(1, 11, 1, 10, 32'h0000000A, 10, 11);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 10, 11);
    #1;
    checkOutput("ovl_count", 64'(busy_count), 64'd1);
    checkOutput("ovl_rd1", 64'(rd_data1), 64'h0000000A);
    checkOutput("ovl_rs2_busy", 64'(rs2_busy), 64'd1);
    applyStimulus(0, 0, 1, 11, 32'h0000000B, 10, 11);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 10, 11);
    #1 checkOutput("ovl_count0", 64'(busy_count), 64'd0);

    // Hardwired zero register ignores issue and writeback
    applyStimulus(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    #1 checkOutput("r0_ready", 64'(issue_ready), 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("r0_data", 64'(rd_data1), 64'd0);
    checkOutput("r0_busy", 64'(rs1_busy), 64'd0);
    checkOutput("r0_count", 64'(busy_count), 64'd0);
    checkOutput("r0_no_err", 64'(err_wb_idle), 64'd0);

    // Forwarding behaviour on r4
    applyStimulus(1, 4, 0, 0, 0, 0, 4);
    tick();
    applyStimulus(0, 0, 1, 4, 32'h11111111, 0, 4);
    tick();
    applyStimulus(1, 4, 0, 0, 0, 0, 4);
    tick();
    applyStimulus(0, 0, 1, 4, 32'h0BADF00D, 0, 4);
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    checkOutput("r4_fwd_data", 64'(rd_data2), 64'h0BADF00D);
    checkOutput("r4_fwd_busy", 64'(rs2_busy), 64'd0);
`else
    checkOutput("r4_old_data", 64'(rd_data2), 64'h11111111);
    checkOutput("r4_old_busy", 64'(rs2_busy), 64'd1);
`endif
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 4);
    #1;
    checkOutput("r4_data", 64'(rd_data2), 64'h0BADF00D);
    checkOutput("r4_busy", 64'(rs2_busy), 64'd0);
    checkOutput("r4_no_err", 64'(err_wb_idle), 64'd0);

    // Writeback to unreserved r9 sets the sticky error
    applyStimulus(0, 0, 1, 9, 32'hCAFE0009, 9, 0);
    #1 checkOutput("r9_err_before", 64'(err_wb_idle), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 9, 0);
    #1;
    checkOutput("r9_err", 64'(err_wb_idle), 64'd1);
    checkOutput("r9_data", 64'(rd_data1), 64'hCAFE0009);
    repeat (3) tick();
    checkOutput("r9_err_sticky", 64'(err_wb_idle), 64'd1);

    // Asynchronous reset mid-operation
    applyStimulus(1, 6, 0, 0, 0, 5, 6);
    tick();
    applyStimulus(0, 0, 1, 5, 32'hDEADBEEF, 5, 6);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 5, 6);
    #1;
    checkOutput("r5_data", 64'(rd_data1), 64'hDEADBEEF);
    checkOutput("r6_count", 64'(busy_count), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_rd1", 64'(rd_data1), 64'd0);
    checkOutput("arst_count", 64'(busy_count), 64'd0);
    checkOutput("arst_err", 64'(err_wb_idle), 64'd0);
    checkOutput("arst_rs2_busy", 64'(rs2_busy), 64'd0);
    applyStimulus(1, 8, 1, 5, 32'h77777777, 5, 6);
    repeat (2) tick();
    applyStimulus(0, 0, 0, 0, 0, 5, 6);
    rst = 1'b0;
    #1;
    checkOutput("rst_hold_data", 64'(rd_data1), 64'd0);
    checkOutput("rst_hold_count", 64'(busy_count), 64'd0);
    applyStimulus(0, 0, 1, 6, 32'h66666666, 6, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 6, 0);
    #1;
    checkOutput("r6_stale_err", 64'(err_wb_idle), 64'd1);
    checkOutput("r6_data", 64'(rd_data1), 64'h66666666);

    repeat (2) tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width.
REQ-002 SHALL provide parameter ADDR_W, default 5, register index width; depth = 2^ADDR_W.
REQ-003 SHALL provide parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-004 SHALL provide clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL provide rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL provide issue_valid  in  1  request to reserve destination issue_rd.
REQ-007 SHALL provide issue_rd  in  ADDR_W  destination index to reserve.
REQ-008 SHALL provide issue_ready  out  1  reservation accepted this cycle when high with issue_valid.
REQ-009 SHALL provide wb_en  in  1  writeback strobe.
REQ-010 SHALL provide wb_rd  in  ADDR_W  writeback index.
REQ-011 SHALL provide wb_data  in  DATA_W  writeback value.
REQ-012 SHALL provide rs1, rs2  in  ADDR_W each  read indices.
REQ-013 SHALL provide rd_data1, rd_data2  out  DATA_W each  read values.
REQ-014 SHALL provide rs1_busy, rs2_busy  out  1 each  source has an outstanding reservation.
REQ-015 SHALL provide busy_count  out  ADDR_W+1  number of reserved registers.
REQ-016 SHALL provide err_wb_idle  out  1  sticky: writeback to an unreserved register occurred.

Function
REQ-017 Storage SHALL be 2^ADDR_W x DATA_W flops plus one busy bit per register.
REQ-018 Reads SHALL be combinational, zero latency; writes SHALL take effect at the next rising edge.
REQ-019 issue_ready SHALL equal NOT busy[issue_rd], combinational; a reserved register blocks re-reservation (WAW stall).
REQ-020 Handshake: issue_valid AND issue_ready at an edge SHALL set busy[issue_rd]; issue_valid without ready SHALL change nothing.
REQ-021 wb_en at an edge SHALL write wb_data to wb_rd and clear busy[wb_rd].
REQ-022 Simultaneous accepted issue and wb to the same index SHALL write the data and leave busy set (issue wins the busy bit).
REQ-023 wb_en to an index whose busy bit is clear (excluding same-edge issue case and index 0 when ZERO_REG=1) SHALL write data and set err_wb_idle.
REQ-024 With ZERO_REG=1, index 0 SHALL read zero, never be busy, issue_ready SHALL be 1 for it, and writes/issues to it SHALL be ignored without flagging err_wb_idle.
REQ-025 busy_count SHALL update each edge: +1 on accepted set, -1 on clear, unchanged when both or neither occur; range 0..2^ADDR_W, no wrap.
REQ-026 Read indices out of no special range; all ADDR_W values SHALL be valid.

Reset
REQ-027 rst high SHALL immediately clear all registers, all busy bits, busy_count and err_wb_idle, independent of clk.
REQ-028 Reset mid-operation SHALL discard all outstanding reservations; a later wb to a formerly reserved index SHALL set err_wb_idle.
REQ-029 While rst is high, edges SHALL not modify state.

Configuration
REQ-030 Macro REGFILE_SB_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 Defined: when wb_en and wb_rd equals rsN (nonzero if ZERO_REG=1), rd_dataN SHALL be wb_data and rsN_busy SHALL be 0 in the same cycle.
REQ-032 Undefined: rd_dataN SHALL be the stored value and rsN_busy the stored busy bit; new data visible one cycle after wb.

Verification
REQ-033 Assert rst mid-test after writing 0xDEADBEEF to r5 -> rd_data1 for rs1=5 reads 0x00000000 before next edge, busy_count=0.
REQ-034 Issue r7, then issue r7 again -> second cycle issue_ready=0, busy_count stays 1; wb r7=0x12345678 -> busy clear, count 0, data read back.
REQ-035 Same-edge issue r3 and wb r3=0xA5A5A5A5 (r3 idle) -> r3=0xA5A5A5A5, busy[r3]=1, count 1, err_wb_idle=0.
REQ-036 wb r9 with r9 unreserved -> data written, err_wb_idle=1 and stays 1 until rst.
REQ-037 Issue r0, wb r0=0xFFFFFFFF (ZERO_REG=1) -> rd_data reads 0, rs_busy=0, count 0, err_wb_idle=0.
REQ-038 With REGFILE_SB_BYPASS_EN: reserve r4, rs2=4, wb r4=0x0BADF00D -> same cycle rd_data2=0x0BADF00D, rs2_busy=0; without it: old value and rs2_busy=1 that cycle.
